// File: rtl/branch_hazard_sched_if.sv
// D-stage / comparator signal bundle for branch_hazard_sched.
// Optional BRANCH_SCHED_STATS_EN adds the stall/resolve/taken counters.
interface branch_hazard_sched_if #(
   parameter int TNEW_W = 2
);
   logic              D_valid;
   logic              D_is_branch;
   logic [2:0]        D_CMPOp;
   logic [4:0]        D_rs;
   logic [4:0]        D_rt;
   logic              D_wr_en;
   logic [4:0]        D_wr_addr;
   logic [TNEW_W-1:0] D_tnew;
   logic              b_result;
   logic              cmp_en;
   logic [2:0]        CMPOp;
   logic              D_stall;
   logic              npc_branch;
   logic              br_taken_q;
   logic              wait_state;
`ifdef BRANCH_SCHED_STATS_EN
   logic [31:0]       stall_cycles;
   logic [31:0]       br_resolved;
   logic [31:0]       br_taken;

   modport master (
      output D_valid, D_is_branch, D_CMPOp, D_rs, D_rt, D_wr_en, D_wr_addr, D_tnew, b_result,
      input  cmp_en, CMPOp, D_stall, npc_branch, br_taken_q, wait_state,
      input  stall_cycles, br_resolved, br_taken
   );
   modport slave (
      input  D_valid, D_is_branch, D_CMPOp, D_rs, D_rt, D_wr_en, D_wr_addr, D_tnew, b_result,
      output cmp_en, CMPOp, D_stall, npc_branch, br_taken_q, wait_state,
      output stall_cycles, br_resolved, br_taken
   );
`else
   modport master (
      output D_valid, D_is_branch, D_CMPOp, D_rs, D_rt, D_wr_en, D_wr_addr, D_tnew, b_result,
      input  cmp_en, CMPOp, D_stall, npc_branch, br_taken_q, wait_state
   );
   modport slave (
      input  D_valid, D_is_branch, D_CMPOp, D_rs, D_rt, D_wr_en, D_wr_addr, D_tnew, b_result,
      output cmp_en, CMPOp, D_stall, npc_branch, br_taken_q, wait_state
   );
`endif
endinterface

// File: rtl/branch_hazard_sched.sv
// D-stage branch scheduler: per-GPR result countdown, branch stall and comparator enable.
// Optional BRANCH_SCHED_STATS_EN adds free-running statistics counters.
module branch_hazard_sched #(
   parameter int NREG   = 32,
   parameter int TNEW_W = 2
) (
   input logic                clk,
   input logic                reset,
   branch_hazard_sched_if.slave bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [TNEW_W-1:0] ZERO = {TNEW_W{1'b0}};
   localparam logic [TNEW_W-1:0] ONE  = TNEW_W'(1'b1);

   logic [TNEW_W-1:0] cnt_r [NREG];
   state_t            state_r;
   state_t            next_state_s;
   logic              rs_busy_s;
   logic              rt_busy_s;
   logic              br_rdy_s;
   logic              stall_s;
   logic              cmp_en_s;
   logic [2:0]        cmpop_s;
   logic              npc_s;
   logic              issue_s;
   logic              br_taken_q_r;

   // Operand readiness, stall and comparator controls from pre-update counters.
   always_comb begin
      rs_busy_s = (bus.D_rs != 5'd0) && (cnt_r[bus.D_rs] != ZERO);
      rt_busy_s = (bus.D_rt != 5'd0) && (cnt_r[bus.D_rt] != ZERO);
      br_rdy_s  = !rs_busy_s && !rt_busy_s;
      stall_s   = bus.D_valid && bus.D_is_branch && !br_rdy_s;
      cmp_en_s  = bus.D_valid && bus.D_is_branch && br_rdy_s;
      if (cmp_en_s) begin
         cmpop_s = bus.D_CMPOp;
      end else begin
         cmpop_s = 3'b000;
      end
      npc_s   = cmp_en_s && bus.b_result;
      issue_s = bus.D_valid && !stall_s && bus.D_wr_en && (bus.D_wr_addr != 5'd0);
   end

   // Scoreboard: a new issue overrides the decrement of its own entry; entry 0 stays zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_r[r] <= ZERO;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (r == 0) begin
               cnt_r[r] <= ZERO;
            end else if (issue_s && (bus.D_wr_addr == 5'(r))) begin
               cnt_r[r] <= bus.D_tnew;
            end else if (cnt_r[r] != ZERO) begin
               cnt_r[r] <= cnt_r[r] - ONE;
            end else begin
               cnt_r[r] <= ZERO;
            end
         end
      end
   end

   // State register and registered taken flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         br_taken_q_r <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         br_taken_q_r <= npc_s;
      end
   end

   // Next-state: WAIT tracks the stall; a dropped D_valid also returns to IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (stall_s) next_state_s = WAIT;
            else         next_state_s = IDLE;
         end
         WAIT: begin
            if (stall_s) next_state_s = WAIT;
            else         next_state_s = IDLE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   assign bus.cmp_en     = cmp_en_s;
   assign bus.CMPOp      = cmpop_s;
   assign bus.D_stall    = stall_s;
   assign bus.npc_branch = npc_s;
   assign bus.br_taken_q = br_taken_q_r;
   assign bus.wait_state = (state_r == WAIT);

`ifdef BRANCH_SCHED_STATS_EN
   logic [31:0] stall_cycles_r;
   logic [31:0] br_resolved_r;
   logic [31:0] br_taken_r;

   // Independent wrapping event counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_r <= 32'd0;
         br_resolved_r  <= 32'd0;
         br_taken_r     <= 32'd0;
      end else begin
         stall_cycles_r <= stall_cycles_r + {31'd0, stall_s};
         br_resolved_r  <= br_resolved_r + {31'd0, cmp_en_s};
         br_taken_r     <= br_taken_r + {31'd0, npc_s};
      end
   end

   assign bus.stall_cycles = stall_cycles_r;
   assign bus.br_resolved  = br_resolved_r;
   assign bus.br_taken     = br_taken_r;
`endif
endmodule

// File: tb/tb_branch_hazard_sched.sv
// Self-checking bench for branch_hazard_sched: vector table plus multi-cycle sequences.
// Also checks the statistics counters when BRANCH_SCHED_STATS_EN is defined.
module tb_branch_hazard_sched;
   typedef struct packed {
      logic       valid;
      logic       is_br;
      logic [2:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       wr_en;
      logic [4:0] wa;
      logic [1:0] tnew;
      logic       bres;
      logic [7:0] exp;   // {stall, cmp_en, CMPOp[2:0], npc_branch, br_taken_q, wait_state}
   } vec_t;

   logic       clk;
   logic       reset;
   int         n_cmp;
   int         n_bad;
   logic [7:0] exp_q [$];
   vec_t       tbl [$];
   int         st_stall;
   int         st_res;
   int         st_tak;

   branch_hazard_sched_if #(.TNEW_W(2)) bus ();

   branch_hazard_sched #(.NREG(32), .TNEW_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ex(input logic stall, input logic cmp, input logic [2:0] op,
                                     input logic npc, input logic tq, input logic ws);
      return {stall, cmp, op, npc, tq, ws};
   endfunction

   function automatic vec_t mk(input logic valid, input logic is_br, input logic [2:0] op,
                               input logic [4:0] rs, input logic [4:0] rt, input logic wr_en,
                               input logic [4:0] wa, input logic [1:0] tnew, input logic bres,
                               input logic [7:0] e);
      vec_t v;
      v.valid = valid; v.is_br = is_br; v.op = op; v.rs = rs; v.rt = rt;
      v.wr_en = wr_en; v.wa = wa; v.tnew = tnew; v.bres = bres; v.exp = e;
      return v;
   endfunction

   function automatic vec_t idle(input logic [7:0] e);
      return mk(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, e);
   endfunction

   function automatic vec_t iss(input logic [4:0] wa, input logic [1:0] tnew, input logic [7:0] e);
      return mk(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 1'b1, wa, tnew, 1'b0, e);
   endfunction

   function automatic vec_t br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic bres, input logic [7:0] e);
      return mk(1'b1, 1'b1, op, rs, rt, 1'b0, 5'd0, 2'd0, bres, e);
   endfunction

   task automatic check_out(input string name);
      logic [7:0] e;
      logic [7:0] a;
      e = exp_q.pop_front();
      a = {bus.D_stall, bus.cmp_en, bus.CMPOp, bus.npc_branch, bus.br_taken_q, bus.wait_state};
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got {stall,cmp_en,CMPOp,npc,taken_q,wait}=%b required %b", name, a, e);
      end
      if (!reset) begin
         st_stall += int'(e[7]);
         st_res   += int'(e[6]);
         st_tak   += int'(e[2]);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      bus.D_valid     = v.valid;
      bus.D_is_branch = v.is_br;
      bus.D_CMPOp     = v.op;
      bus.D_rs        = v.rs;
      bus.D_rt        = v.rt;
      bus.D_wr_en     = v.wr_en;
      bus.D_wr_addr   = v.wa;
      bus.D_tnew      = v.tnew;
      bus.b_result    = v.bres;
      exp_q.push_back(v.exp);
      @(negedge clk);
      check_out(name);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_on();
      reset    = 1'b1;
      st_stall = 0;
      st_res   = 0;
      st_tak   = 0;
      #1;
   endtask

   initial begin
      clk = 1'b0; n_cmp = 0; n_bad = 0;
      st_stall = 0; st_res = 0; st_tak = 0;
      bus.D_valid = 1'b0; bus.D_is_branch = 1'b0; bus.D_CMPOp = 3'd0; bus.D_rs = 5'd0;
      bus.D_rt = 5'd0; bus.D_wr_en = 1'b0; bus.D_wr_addr = 5'd0; bus.D_tnew = 2'd0;
      bus.b_result = 1'b0;

      // Vector table: one row per cycle, starting right after reset release.
      tbl.push_back(idle(ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(iss(5'd8, 2'd2, ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(br(3'b000, 5'd8, 5'd9, 1'b1, ex(1, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(br(3'b000, 5'd8, 5'd9, 1'b1, ex(1, 0, 3'b000, 0, 0, 1)));
      tbl.push_back(br(3'b000, 5'd8, 5'd9, 1'b1, ex(0, 1, 3'b000, 1, 0, 1)));
      tbl.push_back(idle(ex(0, 0, 3'b000, 0, 1, 0)));
      tbl.push_back(br(3'b001, 5'd0, 5'd0, 1'b0, ex(0, 1, 3'b001, 0, 0, 0)));
      tbl.push_back(iss(5'd5, 2'd3, ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(iss(5'd6, 2'd1, ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(br(3'b000, 5'd5, 5'd6, 1'b1, ex(1, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(br(3'b000, 5'd5, 5'd6, 1'b1, ex(1, 0, 3'b000, 0, 0, 1)));
      tbl.push_back(br(3'b000, 5'd5, 5'd6, 1'b1, ex(0, 1, 3'b000, 1, 0, 1)));
      tbl.push_back(idle(ex(0, 0, 3'b000, 0, 1, 0)));
      tbl.push_back(br(3'b101, 5'd0, 5'd3, 1'b0, ex(0, 1, 3'b101, 0, 0, 0)));
      tbl.push_back(iss(5'd9, 2'd3, ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(mk(1'b0, 1'b1, 3'b000, 5'd9, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(br(3'b000, 5'd9, 5'd0, 1'b1, ex(1, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(mk(1'b0, 1'b1, 3'b000, 5'd9, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, ex(0, 0, 3'b000, 0, 0, 1)));
      tbl.push_back(idle(ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(iss(5'd11, 2'd1, ex(0, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(mk(1'b1, 1'b1, 3'b000, 5'd11, 5'd11, 1'b1, 5'd12, 2'd3, 1'b1, ex(1, 0, 3'b000, 0, 0, 0)));
      tbl.push_back(br(3'b000, 5'd12, 5'd12, 1'b1, ex(0, 1, 3'b000, 1, 0, 1)));
      tbl.push_back(iss(5'd13, 2'd0, ex(0, 0, 3'b000, 0, 1, 0)));
      tbl.push_back(br(3'b000, 5'd13, 5'd13, 1'b0, ex(0, 1, 3'b000, 0, 0, 0)));

      // Reset state check while reset is held.
      reset_on();
      apply(idle(ex(0, 0, 3'b000, 0, 0, 0)), "reset_state");
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("tbl[%0d]", i));
      end

      // Same-entry override: the reload to 3 wins over the decrement of 1.
      apply(iss(5'd7, 2'd1, ex(0, 0, 3'b000, 0, 0, 0)), "ovr_iss1");
      apply(iss(5'd7, 2'd3, ex(0, 0, 3'b000, 0, 0, 0)), "ovr_iss3");
      apply(br(3'b000, 5'd7, 5'd7, 1'b1, ex(1, 0, 3'b000, 0, 0, 0)), "ovr_stall1");
      apply(br(3'b000, 5'd7, 5'd7, 1'b1, ex(1, 0, 3'b000, 0, 0, 1)), "ovr_stall2");
      apply(br(3'b000, 5'd7, 5'd7, 1'b1, ex(1, 0, 3'b000, 0, 0, 1)), "ovr_stall3");
      apply(br(3'b000, 5'd7, 5'd7, 1'b1, ex(0, 1, 3'b000, 1, 0, 1)), "ovr_resolve");
      apply(idle(ex(0, 0, 3'b000, 0, 1, 0)), "ovr_taken_q");

      // Reset during WAIT clears the scoreboard and the FSM.
      apply(iss(5'd10, 2'd3, ex(0, 0, 3'b000, 0, 0, 0)), "rst_iss");
      apply(br(3'b000, 5'd10, 5'd10, 1'b1, ex(1, 0, 3'b000, 0, 0, 0)), "rst_stall1");
      apply(br(3'b000, 5'd10, 5'd10, 1'b1, ex(1, 0, 3'b000, 0, 0, 1)), "rst_stall2");
      reset_on();
      apply(br(3'b000, 5'd10, 5'd10, 1'b1, ex(0, 1, 3'b000, 1, 0, 0)), "rst_held");
      reset = 1'b0;
      apply(br(3'b000, 5'd10, 5'd10, 1'b1, ex(0, 1, 3'b000, 1, 0, 0)), "rst_post");
      apply(idle(ex(0, 0, 3'b000, 0, 1, 0)), "rst_taken_q");

      // Fresh reset, then a 2-cycle stall followed by a taken branch.
      reset_on();
      apply(idle(ex(0, 0, 3'b000, 0, 0, 0)), "st_reset");
      reset = 1'b0;
      apply(iss(5'd14, 2'd2, ex(0, 0, 3'b000, 0, 0, 0)), "st_iss");
      apply(br(3'b001, 5'd14, 5'd0, 1'b1, ex(1, 0, 3'b000, 0, 0, 0)), "st_stall1");
      apply(br(3'b001, 5'd14, 5'd0, 1'b1, ex(1, 0, 3'b000, 0, 0, 1)), "st_stall2");
      apply(br(3'b001, 5'd14, 5'd0, 1'b1, ex(0, 1, 3'b001, 1, 0, 1)), "st_resolve");
      apply(idle(ex(0, 0, 3'b000, 0, 1, 0)), "st_idle");
`ifdef BRANCH_SCHED_STATS_EN
      n_cmp++;
      if (bus.stall_cycles !== 32'(st_stall)) begin
         n_bad++;
         $display("FAIL stall_cycles: got %0d required %0d", bus.stall_cycles, st_stall);
      end
      n_cmp++;
      if (bus.br_resolved !== 32'(st_res)) begin
         n_bad++;
         $display("FAIL br_resolved: got %0d required %0d", bus.br_resolved, st_res);
      end
      n_cmp++;
      if (bus.br_taken !== 32'(st_tak)) begin
         n_bad++;
         $display("FAIL br_taken: got %0d required %0d", bus.br_taken, st_tak);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
